// File: rtl/apb_uart_pkg.sv
// Shared constants for the APB UART: register offsets, CTRL/STATUS bit positions
// and the TX/RX frame state encodings.
package apb_uart_pkg;

  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CTRL   = 3'd2;
  localparam logic [2:0] OFF_BAUD   = 3'd3;

  localparam int unsigned ST_TX_EMPTY  = 0;
  localparam int unsigned ST_TX_FULL   = 1;
  localparam int unsigned ST_RX_EMPTY  = 2;
  localparam int unsigned ST_RX_FULL   = 3;
  localparam int unsigned ST_TX_BUSY   = 4;
  localparam int unsigned ST_TX_OVF    = 5;
  localparam int unsigned ST_RX_OVR    = 6;
  localparam int unsigned ST_FRAME_ERR = 7;
  localparam int unsigned ST_PAR_ERR   = 8;

  localparam int unsigned CT_TX_EN   = 0;
  localparam int unsigned CT_RX_EN   = 1;
  localparam int unsigned CT_LOOP    = 2;
  localparam int unsigned CT_PAR_EN  = 3;
  localparam int unsigned CT_PAR_ODD = 4;
  localparam int unsigned CT_STOP2   = 5;
  localparam int unsigned CT_TX_IE   = 6;
  localparam int unsigned CT_RX_IE   = 7;
  localparam int unsigned CT_ERR_IE  = 8;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB UART with TX/RX FIFOs, 16x oversampled receiver, loopback and error flags.
// Define UART_PARITY_EN to make CTRL[4:3] writable and enable parity framing.
module apb_uart_fifo
  import apb_uart_pkg::*;
#(
  parameter int unsigned PADDR_W    = 32,
  parameter int unsigned PDATA_W    = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [PADDR_W-1:0] PADDR,
  input  logic [PDATA_W-1:0] PWDATA,
  output logic [PDATA_W-1:0] PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  input  logic               rxd,
  output logic               txd,
  output logic               irq
);

`ifdef UART_PARITY_EN
  localparam logic [8:0] CTRL_WMASK = 9'h1FF;
`else
  localparam logic [8:0] CTRL_WMASK = 9'h1E7;
`endif

  logic             access, rd_en, wr_en, unmapped;
  logic [2:0]       offset;
  logic             wr_data, wr_status, wr_ctrl, wr_baud, rx_pop;
  logic [8:0]       ctrl_q;
  logic [DIV_W-1:0] div_q, baud_cnt_q, baud_cnt_d;
  logic             baud_tick;
  logic [3:0]       flags_q, flags_d, flags_clr;
  logic [8:0]       status;
  logic             unused_bits;

  assign access    = PSEL & PENABLE;
  assign wr_en     = access & PWRITE;
  assign rd_en     = access & ~PWRITE;
  assign unmapped  = PADDR[4];
  assign offset    = PADDR[4:2];
  assign wr_data   = wr_en & (offset == OFF_DATA);
  assign wr_status = wr_en & (offset == OFF_STATUS);
  assign wr_ctrl   = wr_en & (offset == OFF_CTRL);
  assign wr_baud   = wr_en & (offset == OFF_BAUD);
  assign rx_pop    = rd_en & (offset == OFF_DATA);
  assign PREADY    = 1'b1;
  assign PSLVERR   = access & unmapped;
  assign unused_bits = ^{PADDR[PADDR_W-1:5], PADDR[1:0], PWDATA[PDATA_W-1:9]};

  // FIFOs
  logic       tx_pop, tx_empty, tx_full, rx_push, rx_empty, rx_full;
  logic [7:0] tx_rdata, rx_rdata, rx_sh_q, rx_sh_d;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(PCLK), .rst_i(PRESET), .push_i(wr_data), .pop_i(tx_pop),
    .wdata_i(PWDATA[7:0]), .rdata_o(tx_rdata), .empty_o(tx_empty), .full_o(tx_full)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(PCLK), .rst_i(PRESET), .push_i(rx_push), .pop_i(rx_pop),
    .wdata_i(rx_sh_d), .rdata_o(rx_rdata), .empty_o(rx_empty), .full_o(rx_full)
  );

  assign baud_tick  = (baud_cnt_q == div_q);
  assign baud_cnt_d = (wr_baud || baud_tick) ? '0 : baud_cnt_q + 1'b1;

  // TX FSM
  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_tcnt_q, tx_tcnt_d;
  logic [2:0] tx_bidx_q, tx_bidx_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       tx_par_q, tx_par_d, tx_stop2nd_q, tx_stop2nd_d, txd_q, txd_d;
  logic       tx_bit_end, tx_next;

  assign tx_bit_end = baud_tick && (tx_tcnt_q == 4'hF);
  assign tx_next    = ctrl_q[CT_TX_EN] && !tx_empty;

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_tcnt_d    = baud_tick ? tx_tcnt_q + 4'd1 : tx_tcnt_q;
    tx_bidx_d    = tx_bidx_q;
    tx_sh_d      = tx_sh_q;
    tx_par_d     = tx_par_q;
    tx_stop2nd_d = tx_stop2nd_q;
    tx_pop       = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_tcnt_d = '0;
        if (tx_next) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_rdata;
          tx_par_d   = ^tx_rdata ^ ctrl_q[CT_PAR_ODD];
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_bidx_d  = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_sh_d   = {1'b0, tx_sh_q[7:1]};
        tx_bidx_d = tx_bidx_q + 3'd1;
        if (tx_bidx_q == 3'd7) begin
          tx_stop2nd_d = 1'b0;
          tx_state_d   = ctrl_q[CT_PAR_EN] ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_stop2nd_d = 1'b0;
        tx_state_d   = TX_STOP;
      end
      TX_STOP: if (tx_bit_end) begin
        if (ctrl_q[CT_STOP2] && !tx_stop2nd_q) begin
          tx_stop2nd_d = 1'b1;
        end else if (tx_next) begin
          // chain straight into the next start bit; tcnt has just wrapped to 0
          tx_pop     = 1'b1;
          tx_sh_d    = tx_rdata;
          tx_par_d   = ^tx_rdata ^ ctrl_q[CT_PAR_ODD];
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_q)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = tx_sh_q[0];
      TX_PARITY: txd_d = tx_par_q;
      default:   txd_d = 1'b1;
    endcase
  end

  assign txd = ctrl_q[CT_LOOP] | txd_q;

  // RX FSM
  rx_state_e  rx_state_q, rx_state_d;
  logic [1:0] rx_sync_q;
  logic       rx_s, rx_prev_q, rx_perr_q, rx_perr_d, frame_set, par_set;
  logic [3:0] rx_tcnt_q, rx_tcnt_d;
  logic [2:0] rx_bidx_q, rx_bidx_d;
  logic       rx_mid, rx_bit_end;

  assign rx_s       = rx_sync_q[1];
  assign rx_mid     = baud_tick && (rx_tcnt_q == 4'd7);
  assign rx_bit_end = baud_tick && (rx_tcnt_q == 4'hF);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = baud_tick ? rx_tcnt_q + 4'd1 : rx_tcnt_q;
    rx_bidx_d  = rx_bidx_q;
    rx_sh_d    = rx_sh_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    par_set    = 1'b0;
    if (!ctrl_q[CT_RX_EN]) begin
      rx_state_d = RX_IDLE;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_tcnt_d = '0;
          if (rx_prev_q && !rx_s) rx_state_d = RX_START;
        end
        RX_START: begin
          if (rx_mid && rx_s) begin
            rx_state_d = RX_IDLE;
          end else if (rx_bit_end) begin
            rx_bidx_d  = '0;
            rx_perr_d  = 1'b0;
            rx_state_d = RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_mid) rx_sh_d = {rx_s, rx_sh_q[7:1]};
          if (rx_bit_end) begin
            rx_bidx_d = rx_bidx_q + 3'd1;
            if (rx_bidx_q == 3'd7) rx_state_d = ctrl_q[CT_PAR_EN] ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          if (rx_mid) rx_perr_d = rx_s != (^rx_sh_q ^ ctrl_q[CT_PAR_ODD]);
          if (rx_bit_end) rx_state_d = RX_STOP;
        end
        RX_STOP: if (rx_mid) begin
          rx_push    = 1'b1;
          frame_set  = !rx_s;
          par_set    = rx_perr_q;
          rx_state_d = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a W1C wins.
  assign flags_clr = wr_status ? PWDATA[8:5] : '0;
  assign flags_d   = (flags_q & ~flags_clr) |
                     {par_set, frame_set, rx_push & rx_full & ~rx_pop, wr_data & tx_full & ~tx_pop};
  assign status    = {flags_q, tx_state_q != TX_IDLE, rx_full, rx_empty, tx_full, tx_empty};

  assign irq = (ctrl_q[CT_TX_IE] & tx_empty) | (ctrl_q[CT_RX_IE] & ~rx_empty) |
               (ctrl_q[CT_ERR_IE] & |flags_q);

  always_comb begin
    PRDATA = '0;
    if (rd_en && !unmapped) begin
      case (offset)
        OFF_DATA:   if (!rx_empty) PRDATA[7:0] = rx_rdata;
        OFF_STATUS: PRDATA[8:0] = status;
        OFF_CTRL:   PRDATA[8:0] = ctrl_q;
        OFF_BAUD:   PRDATA[DIV_W-1:0] = div_q;
        default:    PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_q       <= '0;
      div_q        <= '0;
      baud_cnt_q   <= '0;
      flags_q      <= '0;
      tx_state_q   <= TX_IDLE;
      tx_tcnt_q    <= '0;
      tx_bidx_q    <= '0;
      tx_sh_q      <= '0;
      tx_par_q     <= 1'b0;
      tx_stop2nd_q <= 1'b0;
      txd_q        <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_tcnt_q    <= '0;
      rx_bidx_q    <= '0;
      rx_sh_q      <= '0;
      rx_perr_q    <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= PWDATA[8:0] & CTRL_WMASK;
      if (wr_baud) div_q <= PWDATA[DIV_W-1:0];
      baud_cnt_q   <= baud_cnt_d;
      flags_q      <= flags_d;
      tx_state_q   <= tx_state_d;
      tx_tcnt_q    <= tx_tcnt_d;
      tx_bidx_q    <= tx_bidx_d;
      tx_sh_q      <= tx_sh_d;
      tx_par_q     <= tx_par_d;
      tx_stop2nd_q <= tx_stop2nd_d;
      txd_q        <= txd_d;
      rx_state_q   <= rx_state_d;
      rx_sync_q    <= {rx_sync_q[0], ctrl_q[CT_LOOP] ? txd_q : rxd};
      rx_prev_q    <= rx_s;
      rx_tcnt_q    <= rx_tcnt_d;
      rx_bidx_q    <= rx_bidx_d;
      rx_sh_q      <= rx_sh_d;
      rx_perr_q    <= rx_perr_d;
    end
  end

endmodule

// File: doc/apb_uart_fifo.md
# apb_uart_fifo

APB-attached UART with parametrised TX/RX FIFOs, 16x-oversampled receiver, programmable baud divisor, two-stop-bit and loopback modes, error flags and a level interrupt. It is the next generation of the APB UART: one self-contained peripheral on the APB bus with real `txd`/`rxd` pins instead of an internal TX→RX wire. It adds buffering, software-visible status, error detection and an interrupt.

## Interface
- `PADDR_W`, 32: APB address width; only `PADDR[4:2]` is decoded.
- `PDATA_W`, 32: APB data width; characters occupy bits [7:0].
- `FIFO_DEPTH`, 16: entries per FIFO; power of two, ≥2.
- `DIV_W`, 16: baud divisor width.
- `PCLK` in 1: single clock for everything.
- `PRESET` in 1: asynchronous, active-high reset.
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB control.
- `PADDR` in `PADDR_W`: byte address.
- `PWDATA` in `PDATA_W`: write data.
- `PRDATA` out `PDATA_W`: read data; 0 outside read access phase.
- `PREADY` out 1: tied 1 (zero wait states).
- `PSLVERR` out 1: 1 in access phase to an unmapped offset.
- `rxd` in 1: serial input; asynchronous, idles high.
- `txd` out 1: serial output; idles high.
- `irq` out 1: level interrupt.

## Operation
- Register map (offset → register):
  - 0x00 DATA. A write pushes `PWDATA[7:0]` to the TX FIFO. A read pops the RX FIFO. A read while RX is empty returns 0 and does not pop.
  - 0x04 STATUS. Fields: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_busy, [5] tx_ovf, [6] rx_ovr, [7] frame_err, [8] parity_err. Bits [8:5] are sticky and write-1-to-clear; the other bits are read-only.
  - 0x08 CTRL (reset 0). Fields: [0] tx_en, [1] rx_en, [2] loopback, [3] parity_en, [4] parity_odd, [5] stop2, [6] tx_ie, [7] rx_ie, [8] err_ie.
  - 0x0C BAUD_DIV (reset 0). A baud tick occurs every BAUD_DIV+1 `PCLK` cycles; 1 bit = 16 ticks.
  - Offsets 0x10–0x1C: reads return 0 with `PSLVERR`=1; writes are ignored with `PSLVERR`=1.
- Baud counter: free-running, reloads on every write to BAUD_DIV.
- TX FSM, states IDLE→START→DATA→PARITY→STOP→IDLE:
  - Leaves IDLE when tx_en=1 and the TX FIFO is not empty, popping one entry.
  - Frame is LSB first. PARITY is skipped when parity_en=0. STOP lasts 1 bit, or 2 bits when stop2=1.
  - Back-to-back characters have no idle gap.
- RX path: `rxd` passes through a 2-flop synchronizer. With loopback=1, `txd` feeds RX internally and `txd` is held at 1.
- RX FSM, states IDLE→START→DATA→PARITY→STOP:
  - A falling edge in IDLE (rx_en=1) starts a frame. The start bit is re-sampled at tick 7; if high, the FSM returns to IDLE with no flag.
  - Each later bit is sampled at tick 7 of its bit period.
  - Stop bit = 0 sets frame_err, and the character is still pushed.
  - A parity mismatch sets parity_err, and the character is still pushed.
- Overflow:
  - Writing DATA with the TX FIFO full drops the byte and sets tx_ovf.
  - Receiving a character with the RX FIFO full drops the character and sets rx_ovr. FIFO contents are kept.
- `irq` = (tx_ie & tx_empty) | (rx_ie & ~rx_empty) | (err_ie & |STATUS[8:5]).
- Clearing tx_en mid-frame completes the current frame, then the FSM stays IDLE. Clearing rx_en mid-frame aborts to IDLE immediately.

## Timing
- Reset values: `txd`=1, `PRDATA`=0, `PREADY`=1, `PSLVERR`=0, `irq`=0. Both FIFOs are empty, FSMs are IDLE, CTRL, BAUD_DIV and flags are 0.
- Reset is asynchronous mid-frame. `txd` returns to 1 immediately and FIFO contents are lost.
- APB writes take effect on the `PCLK` edge ending the access phase (PSEL&PENABLE). Read data is combinational in the access phase.
- A DATA write into an empty TX FIFO with tx_en=1 starts the start bit within 2 `PCLK` cycles plus at most one baud tick.
- An RX character becomes visible (rx_empty=0) 1 `PCLK` cycle after the stop-bit sample.
- Simultaneous push and pop on a FIFO:
  - Both are performed and the count is unchanged.
  - On a full RX FIFO, a DATA read and an incoming character in the same cycle are both accepted, with no overrun.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap naturally. Full means the MSBs differ and the rest are equal.
- A flag set and a W1C in the same cycle: the set wins.

## Configuration
- `UART_PARITY_EN` defined: CTRL[4:3] are writable and parity is generated and checked as described above.
- `UART_PARITY_EN` undefined:
  - CTRL[4:3] read 0 and writes to them are ignored.
  - STATUS[8] reads 0.
  - No parity logic is synthesized; frames never contain a parity bit.

## Structure
- Package `apb_uart_pkg` holds the register offset constants, the CTRL/STATUS bit-index constants, and the TX and RX state enums.
- One sub-module, `uart_sync_fifo` (parameters WIDTH, DEPTH), is instantiated twice: 8-bit TX and RX.
- The baud counter and both FSMs stay in the top module.

## Test plan
- Loopback at 8N1: BAUD_DIV=3, CTRL=0x07. Write 0x55, 0xA3, 0x00 → after 3 frames (3×10×16×4 `PCLK` cycles plus latency), DATA reads return 0x55, 0xA3, 0x00 in order, then rx_empty=1.
- External `rxd` at 8O2 with `UART_PARITY_EN` defined: drive 0x5A with a correct parity bit, then 0x5A with a wrong parity bit → both characters are pushed; parity_err=1 only after the second. Writing STATUS=0x100 clears it.
- Frame error: drive stop bit = 0 → frame_err=1. With err_ie=1, `irq`=1.
- Overflow, FIFO_DEPTH=4, tx_en=0: write 5 bytes → tx_full=1, tx_ovf=1. Setting tx_en then transmits exactly the first 4 bytes.
- RX overrun: with rx_full, inject 1 more character → rx_ovr=1 and the FIFO holds the original 4 bytes. Also check: a 0x14 read returns 0 with `PSLVERR`=1, and a DATA read while empty returns 0.
- Reset mid-TX frame: assert `PRESET` → `txd`=1 the same cycle and all registers return to their reset values. A glitch on `rxd` shorter than 7 ticks pushes nothing.
